alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: requester 0 is the core pipeline, requester 1 is the cipher (CKA) coprocessor.
- Arbitrates round-robin and drives the ALU operand and control registers.
- Waits a parameterised number of ALU cycles, then returns the result to the granted requester through a valid/ready handshake.
- Rejects unsupported ALU control codes without using the ALU.

---
 rtl/alu_share_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the core
// pipeline (requester 0) and the cipher coprocessor (requester 1).
// One operation in flight at a time. Operands are registered on accept,
// the result is captured after ALU_LAT cycles, and it is returned through
// a valid/ready handshake to the requester that was granted.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [3:0]       req_aluc_0,
  input  logic [3:0]       req_aluc_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_b_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_0,
  input  logic             resp_ready_1,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [3:0]       alu_c,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LAT = 4'(ALU_LAT);

  state_t           state, state_nxt;
  logic             gnt;         // requester owning the in-flight op
  logic             last_grant;  // requester served most recently
  logic [3:0]       cnt;
  logic             sel;
  logic             accept;
  logic             hs;
  logic             sel_legal;
  logic [3:0]       sel_c;
  logic [WIDTH-1:0] sel_a, sel_b;

  function automatic logic legal_code(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0101, 4'b1000, 4'b1001, 4'b1100: legal_code = 1'b1;
      default:                            legal_code = 1'b0;
    endcase
  endfunction

  // Arbitration, operand mux and handshake decode
  always_comb begin
    // Sole requester wins; on a tie, the one not served last time wins
    sel          = (req_valid_0 & req_valid_1) ? ~last_grant : req_valid_1;
    // Ready is held low while reset is asserted so no request is taken
    accept       = rst_n & (state == IDLE) & (req_valid_0 | req_valid_1);
    req_ready_0  = accept & ~sel;
    req_ready_1  = accept & sel;
    sel_c        = sel ? req_aluc_1 : req_aluc_0;
    sel_a        = sel ? req_a_1 : req_a_0;
    sel_b        = sel ? req_b_1 : req_b_0;
    sel_legal    = legal_code(sel_c);
    resp_valid_0 = (state == RESP) & ~gnt;
    resp_valid_1 = (state == RESP) & gnt;
    hs           = gnt ? (resp_valid_1 & resp_ready_1) : (resp_valid_0 & resp_ready_0);
    busy         = (state != IDLE);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = sel_legal ? EXEC : RESP;
      EXEC: if (cnt == 4'd1) state_nxt = RESP;
      RESP: if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ALU operand registers, latency counter, response capture and grant history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      alu_c       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        // ALU registers load even for an illegal code; nobody reads the result
        gnt   <= sel;
        alu_c <= sel_c;
        alu_a <= sel_a;
        alu_b <= sel_b;
        if (sel_legal) begin
          cnt <= LAT;
        end else begin
          resp_err    <= 1'b1;
          resp_result <= '0;
          resp_zero   <= 1'b0;
        end
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          resp_result <= alu_result;
          resp_zero   <= (alu_result == '0);
          resp_err    <= 1'b0;
        end
      end
      if (hs) last_grant <= gnt;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a transaction-level model checked every
// cycle on the main instance (ALU_LAT=1), directed scenarios with literal
// expectations, and a second instance with ALU_LAT=3 for latency/stability.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Main instance (ALU_LAT=1)
  logic         req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [3:0]   req_aluc_0, req_aluc_1;
  logic [W-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic         resp_valid_0, resp_valid_1, resp_ready_0, resp_ready_1;
  logic [W-1:0] resp_result, alu_a, alu_b, alu_result;
  logic         resp_zero, resp_err, busy;
  logic [3:0]   alu_c;

  // Second instance (ALU_LAT=3), only requester 0 used
  logic         q_valid_0, q_valid_1, q_ready_0, q_ready_1;
  logic [3:0]   q_aluc_0, q_aluc_1;
  logic [W-1:0] q_a_0, q_a_1, q_b_0, q_b_1;
  logic         q_rvalid_0, q_rvalid_1, q_rready_0, q_rready_1;
  logic [W-1:0] q_result, q_alu_a, q_alu_b, q_alu_result;
  logic         q_zero, q_err, q_busy;
  logic [3:0]   q_alu_c;

  alu_share_arbiter #(.WIDTH(W), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_aluc_0(req_aluc_0), .req_aluc_1(req_aluc_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_c(alu_c), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .busy(busy)
  );

  alu_share_arbiter #(.WIDTH(W), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(q_valid_0), .req_valid_1(q_valid_1),
    .req_ready_0(q_ready_0), .req_ready_1(q_ready_1),
    .req_aluc_0(q_aluc_0), .req_aluc_1(q_aluc_1),
    .req_a_0(q_a_0), .req_a_1(q_a_1), .req_b_0(q_b_0), .req_b_1(q_b_1),
    .resp_valid_0(q_rvalid_0), .resp_valid_1(q_rvalid_1),
    .resp_ready_0(q_rready_0), .resp_ready_1(q_rready_1),
    .resp_result(q_result), .resp_zero(q_zero), .resp_err(q_err),
    .alu_c(q_alu_c), .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_result(q_alu_result),
    .busy(q_busy)
  );

  // Combinational ALU; illegal codes yield a non-zero junk value
  function automatic logic [W-1:0] alu_f(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0010: alu_f = a ^ b;
      4'b0011: alu_f = ~(a | b);
      4'b0100: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0101: alu_f = ~(a & b);
      4'b1000: alu_f = a + b;
      4'b1001: alu_f = a - b;
      4'b1100: alu_f = {a[15:0], a[31:16]} ^ b;
      default: alu_f = 32'hDEADBEEF;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd12};
  endfunction

  assign alu_result   = alu_f(alu_c, alu_a, alu_b);
  assign q_alu_result = alu_f(q_alu_c, q_alu_a, q_alu_b);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit           m_out, m_own, m_last;
  int           m_wait;
  logic [W-1:0] m_res, p_res, m_a, m_b;
  bit           m_zero, p_zero, m_err;
  logic [3:0]   m_c;
  bit           e_rdy0, e_rdy1, e_rv0, e_rv1;

  // Compare the DUT against the model mid-cycle, then advance the model
  // by what the coming rising edge does with the inputs now present.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_out = 0; m_own = 0; m_last = 1; m_wait = 0;
      m_res = '0; m_zero = 0; m_err = 0; p_res = '0; p_zero = 0;
      m_c = '0; m_a = '0; m_b = '0;
    end
    e_rdy0 = rst_n && !m_out && req_valid_0 && (!req_valid_1 || m_last);
    e_rdy1 = rst_n && !m_out && req_valid_1 && (!req_valid_0 || !m_last);
    e_rv0  = m_out && m_wait == 0 && !m_own;
    e_rv1  = m_out && m_wait == 0 && m_own;
    chk("m_req_ready_0", req_ready_0, e_rdy0);
    chk("m_req_ready_1", req_ready_1, e_rdy1);
    chk("m_resp_valid_0", resp_valid_0, e_rv0);
    chk("m_resp_valid_1", resp_valid_1, e_rv1);
    chk("m_busy", busy, m_out);
    chk("m_resp_result", resp_result, m_res);
    chk("m_resp_zero", resp_zero, m_zero);
    chk("m_resp_err", resp_err, m_err);
    chk("m_alu_c", alu_c, m_c);
    chk("m_alu_a", alu_a, m_a);
    chk("m_alu_b", alu_b, m_b);
    if (rst_n) begin
      if (e_rdy0 || e_rdy1) begin
        m_own = e_rdy1;
        m_c   = m_own ? req_aluc_1 : req_aluc_0;
        m_a   = m_own ? req_a_1 : req_a_0;
        m_b   = m_own ? req_b_1 : req_b_0;
        m_out = 1;
        if (is_legal(m_c)) begin
          p_res  = alu_f(m_c, m_a, m_b);
          p_zero = (p_res == '0);
          m_wait = 1;  // ALU_LAT of the main instance
        end else begin
          m_res = '0; m_zero = 0; m_err = 1; m_wait = 0;
        end
      end else if (m_out && m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_res = p_res; m_zero = p_zero; m_err = 0;
        end
      end else if (m_out && (m_own ? resp_ready_1 : resp_ready_0)) begin
        m_out  = 0;
        m_last = m_own;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // r: 0/1 = main requester, 2 = second instance requester 0
  task automatic wait_ready(input int r);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((r == 0 && req_ready_0) || (r == 1 && req_ready_1) || (r == 2 && q_ready_0)) return;
    end
    checks++; errors++;
    $display("FAIL wait_ready%0d timeout", r);
  endtask

  // Counts cycles after the accept edge until the response shows up
  task automatic wait_rvalid(input int r, output int lat);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if ((r == 0 && resp_valid_0) || (r == 1 && resp_valid_1)) return;
    end
    lat = -1;
    checks++; errors++;
    $display("FAIL wait_rvalid%0d timeout", r);
  endtask

  int lat;

  initial begin
    rst_n = 0;
    req_valid_0 = 0; req_valid_1 = 0; req_aluc_0 = '0; req_aluc_1 = '0;
    req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
    resp_ready_0 = 1; resp_ready_1 = 1;
    q_valid_0 = 0; q_valid_1 = 0; q_aluc_0 = '0; q_aluc_1 = '0;
    q_a_0 = '0; q_a_1 = '0; q_b_0 = '0; q_b_1 = '0;
    q_rready_0 = 1; q_rready_1 = 1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_q_busy", q_busy, 0);

    // 1: lone requester 0, add 5+7
    step();
    rst_n = 1;
    req_valid_0 = 1; req_aluc_0 = 4'b1000; req_a_0 = 5; req_b_0 = 7;
    @(negedge clk);
    chk("t1_ready0", req_ready_0, 1);
    chk("t1_ready1", req_ready_1, 0);
    step();
    req_valid_0 = 0;
    wait_rvalid(0, lat);
    chk("t1_latency", lat, 2);
    chk("t1_result", resp_result, 12);
    chk("t1_zero", resp_zero, 0);
    chk("t1_err", resp_err, 0);
    step();

    // 2: tie from reset, then alternation
    rst_n = 0;
    step();
    rst_n = 1;
    req_valid_0 = 1; req_aluc_0 = 4'b1001; req_a_0 = 9; req_b_0 = 9;
    req_valid_1 = 1; req_aluc_1 = 4'b1100; req_a_1 = 3; req_b_1 = 5;
    @(negedge clk);
    chk("t2_tie_ready0", req_ready_0, 1);
    chk("t2_tie_ready1", req_ready_1, 0);
    step();
    req_aluc_0 = 4'b1000; req_a_0 = 1; req_b_0 = 2;
    wait_rvalid(0, lat);
    chk("t2_sub_result", resp_result, 0);
    chk("t2_sub_zero", resp_zero, 1);
    step();
    @(negedge clk);
    chk("t2_alt_ready1", req_ready_1, 1);
    chk("t2_alt_ready0", req_ready_0, 0);
    step();
    req_valid_1 = 0;
    wait_rvalid(1, lat);
    chk("t2_cka_result", resp_result, 32'h0003_0005);
    step();
    @(negedge clk);
    chk("t2_back_ready0", req_ready_0, 1);
    step();
    req_valid_0 = 0;
    wait_rvalid(0, lat);
    chk("t2_add_result", resp_result, 3);
    step();

    // 3: illegal code on requester 1
    req_valid_1 = 1; req_aluc_1 = 4'b0111; req_a_1 = 1; req_b_1 = 1;
    wait_ready(1);
    step();
    req_valid_1 = 0;
    wait_rvalid(1, lat);
    chk("t3_latency", lat, 1);
    chk("t3_err", resp_err, 1);
    chk("t3_result", resp_result, 0);
    chk("t3_zero", resp_zero, 0);
    step();

    // 4: response back-pressure with a competing request waiting
    resp_ready_0 = 0;
    req_valid_0 = 1; req_aluc_0 = 4'b0000; req_a_0 = 32'hF0F0; req_b_0 = 32'hFF00;
    wait_ready(0);
    step();
    req_valid_0 = 0;
    req_valid_1 = 1; req_aluc_1 = 4'b1000; req_a_1 = 10; req_b_1 = 20;
    wait_rvalid(0, lat);
    chk("t4_result", resp_result, 32'hF000);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("t4_hold_valid0", resp_valid_0, 1);
      chk("t4_hold_result", resp_result, 32'hF000);
      chk("t4_hold_ready1", req_ready_1, 0);
    end
    step();
    resp_ready_0 = 1;
    @(negedge clk);
    chk("t4_hs_ready1", req_ready_1, 0);
    chk("t4_hs_busy", busy, 1);
    step();
    @(negedge clk);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_ready1", req_ready_1, 1);
    step();
    req_valid_1 = 0;
    wait_rvalid(1, lat);
    chk("t4_r1_result", resp_result, 30);
    step();

    // 5: ALU_LAT=3 instance, or 0x00FF | 0xFF00
    q_valid_0 = 1; q_aluc_0 = 4'b0001; q_a_0 = 32'h00FF; q_b_0 = 32'hFF00;
    wait_ready(2);
    step();
    q_valid_0 = 0; q_aluc_0 = 4'b1001; q_a_0 = 32'h1234; q_b_0 = 32'h5678;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t5_exec_rvalid", q_rvalid_0, 0);
      chk("t5_exec_busy", q_busy, 1);
      chk("t5_alu_c", q_alu_c, 4'b0001);
      chk("t5_alu_a", q_alu_a, 32'h00FF);
      chk("t5_alu_b", q_alu_b, 32'hFF00);
    end
    @(negedge clk);
    chk("t5_rvalid_at4", q_rvalid_0, 1);
    chk("t5_result", q_result, 32'hFFFF);
    chk("t5_zero", q_zero, 0);
    step();

    // 6: reset during EXEC, then a fresh tie
    req_valid_0 = 1; req_aluc_0 = 4'b1000; req_a_0 = 100; req_b_0 = 1;
    wait_ready(0);
    step();
    req_valid_0 = 0;
    #1 rst_n = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_rvalid0", resp_valid_0, 0);
    chk("t6_rvalid1", resp_valid_1, 0);
    chk("t6_alu_a", alu_a, 0);
    step();
    rst_n = 1;
    req_valid_0 = 1; req_aluc_0 = 4'b0010; req_a_0 = 6; req_b_0 = 3;
    req_valid_1 = 1; req_aluc_1 = 4'b0001; req_a_1 = 0; req_b_1 = 0;
    @(negedge clk);
    chk("t6_tie_ready0", req_ready_0, 1);
    chk("t6_tie_ready1", req_ready_1, 0);
    step();
    req_valid_0 = 0; req_valid_1 = 0;
    wait_rvalid(0, lat);
    chk("t6_latency", lat, 2);
    chk("t6_result", resp_result, 5);
    step();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
